// File: rtl/idli_sx_m.sv
// -----------------------------------------------------------------------------
// idli_sx_m - bit-serial execution unit
//
// Executes one DATA_W-wide ALU operation as SLICES = DATA_W/SLICE_W slices,
// least-significant slice first, one slice per clock. The slice index is
// driven to the register file, which returns the B/C operand slices in the
// same cycle. Result slices are written back with o_sx_res_vld as the write
// enable. A carry chain links consecutive slices, and carry/zero flags are
// registered when the final slice completes.
//
// Handshake: an instruction on i_sx_op/i_sx_op_vld is taken on any clock edge
// where o_sx_op_acp is high. Acceptance happens in IDLE or on the last slice of
// the running op (when not stalled), so back-to-back ops run with no bubble.
// An accept with i_sx_op_vld low returns the unit to IDLE.
//
// Optional feature macro: IDLI_SX_ZERO_FLAG_EN
//   defined   : zero-result tracking drives o_sx_flag_z
//   undefined : no tracking logic, o_sx_flag_z tied 0
//
// Ports
//   i_sx_gck       clock
//   i_sx_rst_n     asynchronous active-low reset
//   i_sx_op        ALU opcode of the offered instruction
//   i_sx_op_vld    offered instruction valid
//   o_sx_op_acp    instruction accepted this cycle
//   i_sx_stall     freeze the current slice
//   o_sx_slice     slice index being executed (register file read address)
//   i_sx_b_data    B operand slice
//   i_sx_c_data    C operand slice
//   o_sx_res_data  result slice
//   o_sx_res_vld   result slice valid (register file write enable)
//   o_sx_done      final slice completing this cycle
//   o_sx_flag_c    carry flag (registered)
//   o_sx_flag_z    zero flag (registered)
// -----------------------------------------------------------------------------
module idli_sx_m #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic                                 i_sx_gck,
    input  logic                                 i_sx_rst_n,
    input  logic [2:0]                           i_sx_op,
    input  logic                                 i_sx_op_vld,
    output logic                                 o_sx_op_acp,
    input  logic                                 i_sx_stall,
    output logic [$clog2(DATA_W/SLICE_W)-1:0]    o_sx_slice,
    input  logic [SLICE_W-1:0]                   i_sx_b_data,
    input  logic [SLICE_W-1:0]                   i_sx_c_data,
    output logic [SLICE_W-1:0]                   o_sx_res_data,
    output logic                                 o_sx_res_vld,
    output logic                                 o_sx_done,
    output logic                                 o_sx_flag_c,
    output logic                                 o_sx_flag_z
);

    localparam int SLICES = DATA_W / SLICE_W;
    localparam int CTR_W  = $clog2(SLICES);
    localparam logic [CTR_W-1:0] LAST_SLICE = CTR_W'(SLICES - 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MOVB = 3'd5;
    localparam logic [2:0] OP_MOVC = 3'd6;

    // RUN is exactly "an accepted valid op is in flight", so the state
    // register doubles as the op-valid register.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CTR_W-1:0]     ctr_q, ctr_d;
    logic [2:0]           op_q, op_d;
    logic                 carry_q, carry_d;
    logic                 flag_c_q, flag_c_d;

    logic                 last_slice;
    logic [SLICE_W-1:0]   c_opnd;
    logic                 cin;
    logic [SLICE_W:0]     sum;
    logic [SLICE_W-1:0]   res;
    logic                 res_is_zero;

    assign last_slice  = (ctr_q == LAST_SLICE);
    assign o_sx_slice  = ctr_q;
    assign o_sx_flag_c = flag_c_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_sx_gck or negedge i_sx_rst_n) begin
        if (!i_sx_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (o_sx_op_acp) begin
            state_d = i_sx_op_vld ? ST_RUN : ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_sx_op_acp  = 1'b0;
        o_sx_res_vld = 1'b0;
        o_sx_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_sx_op_acp = 1'b1;
            end
            ST_RUN: begin
                o_sx_res_vld = !i_sx_stall;
                o_sx_op_acp  = last_slice && !i_sx_stall;
                o_sx_done    = last_slice && !i_sx_stall;
            end
            default: begin
                o_sx_op_acp = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slice datapath
    // ------------------------------------------------------------------
    always_comb begin
        c_opnd = (op_q == OP_SUB) ? ~i_sx_c_data : i_sx_c_data;
        // Slice 0 starts the chain from the op's own carry-in (1 for SUB
        // to complete the two's-complement negate); later slices chain.
        cin    = (ctr_q == '0) ? (op_q == OP_SUB) : carry_q;
        sum    = {1'b0, i_sx_b_data} + {1'b0, c_opnd} + {{SLICE_W{1'b0}}, cin};

        case (op_q)
            OP_ADD,
            OP_SUB:  res = sum[SLICE_W-1:0];
            OP_AND:  res = i_sx_b_data & i_sx_c_data;
            OP_OR:   res = i_sx_b_data | i_sx_c_data;
            OP_XOR:  res = i_sx_b_data ^ i_sx_c_data;
            OP_MOVB: res = i_sx_b_data;
            OP_MOVC: res = i_sx_c_data;
            default: res = '0;
        endcase
    end

    assign res_is_zero   = (res == '0);
    assign o_sx_res_data = (state_q == ST_RUN) ? res : '0;

    // ------------------------------------------------------------------
    // Counter, opcode, carry chain and carry flag
    // ------------------------------------------------------------------
    always_comb begin
        ctr_d    = ctr_q;
        op_d     = op_q;
        carry_d  = carry_q;
        flag_c_d = flag_c_q;

        if (o_sx_op_acp) begin
            ctr_d = '0;
            op_d  = i_sx_op;
        end else if (o_sx_res_vld) begin
            ctr_d = ctr_q + CTR_W'(1);
        end

        if (o_sx_res_vld) begin
            carry_d = sum[SLICE_W];
        end

        // Flags use the op still in op_q even when a new op is accepted on
        // the same edge.
        if (o_sx_done && (op_q == OP_ADD || op_q == OP_SUB)) begin
            flag_c_d = sum[SLICE_W];
        end
    end

    always_ff @(posedge i_sx_gck or negedge i_sx_rst_n) begin
        if (!i_sx_rst_n) begin
            ctr_q    <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            flag_c_q <= flag_c_d;
        end
    end

    // ------------------------------------------------------------------
    // Zero flag
    // ------------------------------------------------------------------
`ifdef IDLI_SX_ZERO_FLAG_EN
    logic nz_seen_q, nz_seen_d;
    logic flag_z_q, flag_z_d;

    always_comb begin
        nz_seen_d = nz_seen_q;
        flag_z_d  = flag_z_q;

        // Accept wins over the final slice's update: the accumulator must
        // start clean for the incoming op.
        if (o_sx_op_acp) begin
            nz_seen_d = 1'b0;
        end else if (o_sx_res_vld && !res_is_zero) begin
            nz_seen_d = 1'b1;
        end

        // The final slice is folded in combinationally; reserved op 7
        // leaves the flag alone.
        if (o_sx_done && (op_q != 3'd7)) begin
            flag_z_d = !nz_seen_q && res_is_zero;
        end
    end

    always_ff @(posedge i_sx_gck or negedge i_sx_rst_n) begin
        if (!i_sx_rst_n) begin
            nz_seen_q <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            nz_seen_q <= nz_seen_d;
            flag_z_q  <= flag_z_d;
        end
    end

    assign o_sx_flag_z = flag_z_q;
`else
    logic unused_zero;
    assign unused_zero = res_is_zero;
    assign o_sx_flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_idli_sx_m.sv
// -----------------------------------------------------------------------------
// tb_idli_sx_m - directed self-checking bench for idli_sx_m
//
// Two instances: the default 16-bit / 4-bit-slice unit and a 32-bit /
// 8-bit-slice unit. Each has a small register-file model that returns the
// operand slice addressed by o_sx_slice. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_idli_sx_m;

`ifdef IDLI_SX_ZERO_FLAG_EN
    localparam logic ZEN = 1'b1;
`else
    localparam logic ZEN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // 16/4 instance
    // ------------------------------------------------------------------
    logic [2:0]  op;
    logic        op_vld;
    logic        op_acp;
    logic        stall;
    logic [1:0]  slice;
    logic [3:0]  b_data;
    logic [3:0]  c_data;
    logic [3:0]  res_data;
    logic        res_vld;
    logic        done;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] b_word;
    logic [15:0] c_word;

    idli_sx_m #(.DATA_W(16), .SLICE_W(4)) dut (
        .i_sx_gck      (clk),
        .i_sx_rst_n    (rst_n),
        .i_sx_op       (op),
        .i_sx_op_vld   (op_vld),
        .o_sx_op_acp   (op_acp),
        .i_sx_stall    (stall),
        .o_sx_slice    (slice),
        .i_sx_b_data   (b_data),
        .i_sx_c_data   (c_data),
        .o_sx_res_data (res_data),
        .o_sx_res_vld  (res_vld),
        .o_sx_done     (done),
        .o_sx_flag_c   (flag_c),
        .o_sx_flag_z   (flag_z)
    );

    always_comb begin
        b_data = b_word[{slice, 2'b00} +: 4];
        c_data = c_word[{slice, 2'b00} +: 4];
    end

    // ------------------------------------------------------------------
    // 32/8 instance
    // ------------------------------------------------------------------
    logic [2:0]  op2;
    logic        op_vld2;
    logic        op_acp2;
    logic        stall2;
    logic [1:0]  slice2;
    logic [7:0]  b_data2;
    logic [7:0]  c_data2;
    logic [7:0]  res_data2;
    logic        res_vld2;
    logic        done2;
    logic        flag_c2;
    logic        flag_z2;
    logic [31:0] b_word2;
    logic [31:0] c_word2;

    idli_sx_m #(.DATA_W(32), .SLICE_W(8)) dut32 (
        .i_sx_gck      (clk),
        .i_sx_rst_n    (rst_n),
        .i_sx_op       (op2),
        .i_sx_op_vld   (op_vld2),
        .o_sx_op_acp   (op_acp2),
        .i_sx_stall    (stall2),
        .o_sx_slice    (slice2),
        .i_sx_b_data   (b_data2),
        .i_sx_c_data   (c_data2),
        .o_sx_res_data (res_data2),
        .o_sx_res_vld  (res_vld2),
        .o_sx_done     (done2),
        .o_sx_flag_c   (flag_c2),
        .o_sx_flag_z   (flag_z2)
    );

    always_comb begin
        b_data2 = b_word2[{slice2, 3'b000} +: 8];
        c_data2 = c_word2[{slice2, 3'b000} +: 8];
    end

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: issue one op on the 16/4 unit from IDLE and check it through
    // ------------------------------------------------------------------
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [15:0] b, input logic [15:0] c,
                          input logic [15:0] exp_res, input logic exp_fc,
                          input logic exp_fz);
        logic [15:0] got;
        got = '0;
        chk({tag, "_acp_idle"}, op_acp, 1);
        op     = o;
        op_vld = 1'b1;
        b_word = b;
        c_word = c;
        @(posedge clk); #1;
        op_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk({tag, "_slice"}, slice, i);
            chk({tag, "_res_vld"}, res_vld, 1);
            chk({tag, "_done"}, done, (i == 3));
            got[i*4 +: 4] = res_data;
            @(posedge clk); #1;
        end
        chk({tag, "_res"}, got, exp_res);
        chk({tag, "_flag_c"}, flag_c, exp_fc);
        chk({tag, "_flag_z"}, flag_z, exp_fz);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [15:0] gx;
        logic [15:0] ga;
        logic [15:0] gs;
        logic [31:0] g32;

        rst_n   = 1'b0;
        op      = 3'd0;
        op_vld  = 1'b0;
        stall   = 1'b0;
        b_word  = '0;
        c_word  = '0;
        op2     = 3'd0;
        op_vld2 = 1'b0;
        stall2  = 1'b0;
        b_word2 = '0;
        c_word2 = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        b_word = 16'h1234;
        c_word = 16'h0FFF;
        #1;
        chk("rst_acp", op_acp, 1);
        chk("rst_slice", slice, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_flag_c", flag_c, 0);
        chk("rst_flag_z", flag_z, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic ADD; slices 3,3,2,2 LSB first
        run_op("add_1234_0fff", 3'd0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
        // Carry ripples through every slice
        run_op("add_ffff_1", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, ZEN);
        // Reserved op: result 0, flags untouched
        run_op("op7", 3'd7, 16'h0000, 16'h0000, 16'h0000, 1'b1, ZEN);
        // SUB
        run_op("sub_3_4", 3'd1, 16'h0003, 16'h0004, 16'hFFFF, 1'b0, 1'b0);
        run_op("sub_5_5", 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, ZEN);
        // Logic and moves leave flag_c alone
        run_op("or", 3'd3, 16'h1200, 16'h0034, 16'h1234, 1'b1, 1'b0);
        run_op("movb", 3'd5, 16'hBEEF, 16'h1111, 16'hBEEF, 1'b1, 1'b0);
        run_op("movc", 3'd6, 16'hBEEF, 16'h0000, 16'h0000, 1'b1, ZEN);

        // Back-to-back XOR (nonzero) then AND (zero), op valid held
        gx = '0;
        ga = '0;
        op     = 3'd4;
        op_vld = 1'b1;
        b_word = 16'h00FF;
        c_word = 16'h0F0F;
        @(posedge clk); #1;
        op = 3'd2;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                b_word = 16'h0F0F;
                c_word = 16'hF0F0;
                op_vld = 1'b0;
                chk("b2b_xor_flag_c", flag_c, 1);
                chk("b2b_xor_flag_z", flag_z, 0);
            end
            #1;
            chk("b2b_slice", slice, i % 4);
            chk("b2b_res_vld", res_vld, 1);
            chk("b2b_acp", op_acp, ((i % 4) == 3));
            if (i < 4) gx[(i%4)*4 +: 4] = res_data;
            else       ga[(i%4)*4 +: 4] = res_data;
            @(posedge clk); #1;
        end
        chk("b2b_xor_res", gx, 16'h0FF0);
        chk("b2b_and_res", ga, 16'h0000);
        chk("b2b_and_flag_c", flag_c, 1);
        chk("b2b_and_flag_z", flag_z, ZEN);
        chk("b2b_idle_acp", op_acp, 1);

        // Stall in IDLE changes nothing
        stall = 1'b1;
        #1;
        chk("idle_stall_acp", op_acp, 1);
        chk("idle_stall_res_vld", res_vld, 0);
        stall = 1'b0;

        // ADD 0x00F8+0x0008 with slice 1 stalled 3 cycles: 7 cycles total
        gs = '0;
        op     = 3'd0;
        op_vld = 1'b1;
        b_word = 16'h00F8;
        c_word = 16'h0008;
        @(posedge clk); #1;
        op_vld = 1'b0;
        #1;
        chk("stall_s0_slice", slice, 0);
        chk("stall_s0_res_vld", res_vld, 1);
        gs[3:0] = res_data;
        @(posedge clk); #1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_hold_slice", slice, 1);
            chk("stall_hold_res_vld", res_vld, 0);
            chk("stall_hold_acp", op_acp, 0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("stall_run_slice", slice, i);
            chk("stall_run_res_vld", res_vld, 1);
            chk("stall_run_done", done, (i == 3));
            gs[i*4 +: 4] = res_data;
            @(posedge clk); #1;
        end
        chk("stall_res", gs, 16'h0100);
        chk("stall_flag_c", flag_c, 0);
        chk("stall_flag_z", flag_z, 0);

        // Set flags, then reset in the middle of the next op
        run_op("pre_rst_add", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, ZEN);
        op     = 3'd0;
        op_vld = 1'b1;
        b_word = 16'h1111;
        c_word = 16'h1111;
        @(posedge clk); #1;
        op_vld = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_slice", slice, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acp", op_acp, 1);
        chk("mid_rst_res_vld", res_vld, 0);
        chk("mid_rst_slice", slice, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_flag_c", flag_c, 0);
        chk("mid_rst_flag_z", flag_z, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_res_vld", res_vld, 0);
        chk("post_rst_flag_c", flag_c, 0);

        // 32/8 unit: ADD 0xFFFFFFFF+1 over 4 slices
        g32 = '0;
        chk("w32_acp_idle", op_acp2, 1);
        op2     = 3'd0;
        op_vld2 = 1'b1;
        b_word2 = 32'hFFFF_FFFF;
        c_word2 = 32'h0000_0001;
        @(posedge clk); #1;
        op_vld2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w32_slice", slice2, i);
            chk("w32_res_vld", res_vld2, 1);
            chk("w32_done", done2, (i == 3));
            g32[i*8 +: 8] = res_data2;
            @(posedge clk); #1;
        end
        chk("w32_res", g32, 32'h0000_0000);
        chk("w32_flag_c", flag_c2, 1);
        chk("w32_flag_z", flag_z2, ZEN);
        chk("w32_idle_res_vld", res_vld2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
